// File: rtl/data_ram_responder.sv
// Single-port data RAM for the CPU load/store path, with a hardware clear sweep
// that zeroes every word, one per enabled cycle.
module data_ram_responder #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              resIn,
   input  logic              enable,
   input  logic [ADDR_W-1:0] dataAddr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData,
   input  logic              selData,
   input  logic              ldData,
   input  logic              clrData,
   output logic              busy,
   output logic              clrDone
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t            state, stateNxt;
   logic [ADDR_W-1:0] counter, counterNxt;
   logic              doneNxt;
   logic              rdLoad, rdZero;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk or negedge resIn) begin
      if (!resIn) begin
         state   <= IDLE;
         counter <= '0;
         clrDone <= 1'b0;
      end else begin
         state   <= stateNxt;
         counter <= counterNxt;
         clrDone <= doneNxt;
      end
   end

   always_comb begin
      stateNxt   = state;
      counterNxt = counter;
      doneNxt    = 1'b0;
      rdLoad     = 1'b0;
      rdZero     = 1'b0;
      memWe      = 1'b0;
      memAddr    = dataAddr;
      memWdata   = wrData;
      if (enable) begin
         case (state)
            IDLE: begin
               // A clear request wins over a load/store in the same cycle.
               if (clrData) begin
                  stateNxt   = CLEAR;
                  counterNxt = '0;
                  rdZero     = 1'b1;
               end else if (selData) begin
                  if (ldData) rdLoad = 1'b1;
                  else        memWe  = 1'b1;
               end
            end
            CLEAR: begin
               memWe    = 1'b1;
               memAddr  = counter;
               memWdata = '0;
               rdZero   = 1'b1;
               // A held or re-asserted clear restarts the sweep and suppresses clrDone.
               if (clrData) begin
                  counterNxt = '0;
               end else if (counter == LAST) begin
                  stateNxt   = IDLE;
                  counterNxt = '0;
                  doneNxt    = 1'b1;
               end else begin
                  counterNxt = counter + 1'b1;
               end
            end
            default: stateNxt = IDLE;
         endcase
      end
   end

   // Memory is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (memWe) mem[memAddr] <= memWdata;
   end

   always_ff @(posedge clk or negedge resIn) begin
      if (!resIn)      rdData <= '0;
      else if (rdZero) rdData <= '0;
      else if (rdLoad) rdData <= mem[dataAddr];
   end

   assign busy = (state == CLEAR);

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: load/store, clear sweep, pause, restart, reset.
module tb_data_ram_responder;

   logic        clk = 1'b0;
   logic        resIn;
   logic        enable;
   logic [11:0] dataAddr;
   logic [15:0] wrData;
   logic [15:0] rdData;
   logic        selData;
   logic        ldData;
   logic        clrData;
   logic        busy;
   logic        clrDone;

   int errors = 0;
   int checks = 0;

   data_ram_responder #(.ADDR_W(12), .DATA_W(16)) dut (
      .clk(clk), .resIn(resIn), .enable(enable), .dataAddr(dataAddr),
      .wrData(wrData), .rdData(rdData), .selData(selData), .ldData(ldData),
      .clrData(clrData), .busy(busy), .clrDone(clrDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleIn();
      selData = 1'b0; ldData = 1'b0; clrData = 1'b0; enable = 1'b1;
   endtask

   task automatic store(input logic [11:0] a, input logic [15:0] d);
      selData = 1'b1; ldData = 1'b0; dataAddr = a; wrData = d;
      step();
      selData = 1'b0;
   endtask

   task automatic load(input logic [11:0] a);
      selData = 1'b1; ldData = 1'b1; dataAddr = a;
      step();
      selData = 1'b0; ldData = 1'b0;
   endtask

   task automatic startClear();
      clrData = 1'b1;
      step();
      clrData = 1'b0;
   endtask

   // Bounded wait for the sweep to end; n is the number of edges until busy drops.
   task automatic runToIdle(input string tag, input int expN);
      int n, early;
      n = 0; early = 0;
      do begin
         step();
         n++;
         if (busy && clrDone) early++;
      end while (busy && n < 6000);
      chk({tag, "_len"}, n, expN);
      chk({tag, "_early_done"}, early, 0);
      chk({tag, "_done"}, {31'd0, clrDone}, 1);
      step();
      chk({tag, "_done_1cyc"}, {31'd0, clrDone}, 0);
   endtask

   initial begin
      resIn = 1'b0; enable = 1'b1; dataAddr = '0; wrData = '0;
      selData = 1'b0; ldData = 1'b0; clrData = 1'b0;
      #3;
      chk("rst_rd", rdData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", clrDone, 0);
      @(negedge clk);
      resIn = 1'b1;

      // First edge after reset release performs the store.
      store(12'h005, 16'hBEEF);
      chk("st_rd_hold", rdData, 0);
      load(12'h005);
      chk("ld_beef", rdData, 16'hBEEF);
      step();
      chk("nosel_hold", rdData, 16'hBEEF);

      enable = 1'b0;
      store(12'h005, 16'h1111);
      load(12'h020);
      chk("en0_hold", rdData, 16'hBEEF);
      enable = 1'b1;
      load(12'h005);
      chk("en0_nowrite", rdData, 16'hBEEF);

      // Async reset clears rdData immediately but keeps memory.
      #2 resIn = 1'b0;
      #1 chk("async_rd", rdData, 0);
      @(negedge clk);
      resIn = 1'b1;
      load(12'h005);
      chk("rst_keep_mem", rdData, 16'hBEEF);

      store(12'h0FFF, 16'h1234);
      load(12'hFFF);
      chk("ld_fff", rdData, 16'h1234);

      // Full sweep; store requested alongside the clear is dropped.
      selData = 1'b1; ldData = 1'b0; dataAddr = 12'h005; wrData = 16'hDEAD;
      startClear();
      selData = 1'b0;
      chk("clr_busy", busy, 1);
      chk("clr_rd0", rdData, 0);
      for (int i = 0; i < 20; i++) step();
      store(12'h010, 16'hAAAA);
      load(12'hFFF);
      chk("clr_ld_zero", rdData, 0);
      runToIdle("sweep1", 4096 - 22);
      load(12'h005);
      chk("sw_005", rdData, 0);
      store(12'h0FF0, 16'h0BAD);
      load(12'hFFF);
      chk("sw_fff", rdData, 0);
      load(12'h010);
      chk("sw_010", rdData, 0);
      load(12'hFF0);
      chk("post_store", rdData, 16'h0BAD);

      // Pause at counter 0x100 for ten disabled cycles.
      startClear();
      for (int i = 0; i < 256; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("pause_busy", busy, 1);
      chk("pause_done", clrDone, 0);
      enable = 1'b1;
      runToIdle("pause", 4096 - 256);

      // Re-assert clear mid-sweep: counter restarts.
      startClear();
      for (int i = 0; i < 100; i++) step();
      startClear();
      chk("restart_busy", busy, 1);
      runToIdle("restart", 4096);

      // Clear held on the completing edge restarts without a pulse.
      startClear();
      for (int i = 0; i < 4095; i++) step();
      clrData = 1'b1;
      step();
      clrData = 1'b0;
      chk("hold_busy", busy, 1);
      chk("hold_nodone", clrDone, 0);
      runToIdle("hold", 4096);

      // Reset mid-sweep abandons it; words above the counter survive.
      store(12'h0FFF, 16'h1234);
      store(12'h005, 16'h7777);
      startClear();
      for (int i = 0; i < 50; i++) step();
      #2 resIn = 1'b0;
      #1 chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd", rdData, 0);
      chk("mid_rst_done", clrDone, 0);
      @(negedge clk);
      resIn = 1'b1;
      load(12'hFFF);
      chk("partial_fff", rdData, 16'h1234);
      load(12'h005);
      chk("partial_005", rdData, 0);
      step();
      chk("idle_after_rst", busy, 0);

      idleIn();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning address width; memory depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resIn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  global enable; when low, no read, write or clear sweep advance occurs.
REQ-006 SHALL have port dataAddr  input  ADDR_W  word address of access.
REQ-007 SHALL have port wrData  input  DATA_W  store data, driven by the CPU dataOut.
REQ-008 SHALL have port rdData  output  DATA_W  load data, registered, driven to the CPU dataIn.
REQ-009 SHALL have port selData  input  1  access request.
REQ-010 SHALL have port ldData  input  1  access type: 1 = load, 0 = store; meaningful only with selData high.
REQ-011 SHALL have port clrData  input  1  clear request; level-sensitive, sampled each clock.
REQ-012 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-013 SHALL have port clrDone  output  1  single-cycle pulse when a clear sweep completes.

Function
REQ-014 SHALL contain a single-port array of 2**ADDR_W words of DATA_W bits.
REQ-015 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-016 In IDLE, with enable=1 and clrData=0: selData=1, ldData=1 -> rdData <= mem[dataAddr] at that edge; latency 1 cycle.
REQ-017 In IDLE, with enable=1 and clrData=0: selData=1, ldData=0 -> mem[dataAddr] <= wrData at that edge; rdData holds.
REQ-018 With selData=0, or enable=0, memory and rdData SHALL hold.
REQ-019 In IDLE, clrData=1 with enable=1 -> next state CLEAR, sweep counter <= 0, busy <= 1; a load or store requested in the same cycle is dropped.
REQ-020 In CLEAR with enable=1: mem[counter] <= 0, counter <= counter+1, one word per cycle.
REQ-021 In CLEAR with enable=0: the counter and memory SHALL hold, and busy stays 1.
REQ-022 When the counter equals 2**ADDR_W-1 and is written, the FSM SHALL return to IDLE, with busy <= 0 and clrDone <= 1 for exactly one cycle; sweep length is 2**ADDR_W enabled cycles, with no wrap.
REQ-023 clrData=1 sampled during CLEAR SHALL restart the sweep with counter <= 0 and SHALL NOT pulse clrDone.
REQ-024 In CLEAR, selData requests SHALL be ignored (no write), and rdData SHALL read 0.
REQ-025 If clrData is still high on the completing edge, the sweep restarts per REQ-023 and clrDone SHALL NOT pulse.

Reset
REQ-026 resIn=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, rdData=0, busy=0, clrDone=0.
REQ-027 Reset SHALL NOT alter memory contents; an interrupted sweep is abandoned, leaving partially cleared contents.
REQ-028 After resIn rises, the first rising clk edge SHALL be able to process a request.

Verification
REQ-029 Store 16'hBEEF to address 12'h005, then load 12'h005 -> rdData=16'hBEEF one cycle after the load edge.
REQ-030 Store 16'h1234 to address 12'hFFF, then pulse clrData 1 cycle -> busy=1 for 4096 cycles, clrDone pulses once; loads of 12'h005 and 12'hFFF then return 16'h0000.
REQ-031 Mid-sweep at counter 12'h100, drive enable=0 for 10 cycles -> counter holds at 12'h100, and the sweep completes 4096 enabled cycles after its start.
REQ-032 Mid-sweep, re-assert clrData -> the counter restarts at 0, with no clrDone until 4096 further cycles.
REQ-033 Mid-sweep, assert resIn=0 between clock edges -> busy=0 and rdData=0 at once; words above the counter retain their old values (e.g. 12'hFFF=16'h1234).
REQ-034 While busy=1, store 16'hAAAA to 12'h010 -> after the sweep, a load of 12'h010 returns 16'h0000.
